press_pulser: RTL

- Transmit side of the player-press interface: turns one raw, bouncy, active-low pushbutton into the clean single-cycle press pulse that the light cells consume on their L/R inputs.
- Provides two-flop synchronization, symmetric debounce, exactly one pulse per physical press, suppression while lose is high, and a wrapping press counter for score/debug display.
- Two instances per game sit between the board keys and the light chain, one for the left player and one for the right player.

---
 rtl/press_pulser_pkg.sv | 13 +
 rtl/press_pulser_sync2.sv | 30 +++
 rtl/press_pulser.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/press_pulser_pkg.sv
// Shared types and defaults for the player pushbutton front end.
package press_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    PRESSED = 2'd2,
    DROP    = 2'd3
  } press_state_e;

  localparam int DEBOUNCE_DEFAULT = 4;

endpackage

// File: rtl/press_pulser_sync2.sv
// Two-flop synchronizer for asynchronous board inputs.
module sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic sync_o
);

  logic [1:0] chain_d;
  logic [1:0] chain_q;

  // next value of the shift chain
  always_comb begin
    chain_d = {chain_q[0], async_i};
  end

  // synchronizer flops, reset to the inactive input level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_q <= {RST_VAL, RST_VAL};
    end else begin
      chain_q <= chain_d;
    end
  end

  assign sync_o = chain_q[1];

endmodule

// File: rtl/press_pulser.sv
// Debounced single-pulse press generator for one player key, with a wrapping press counter.
module press_pulser
  import press_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             lose,
  input  logic             key_n,
  output logic             press,
  output logic             held,
  output logic [CNT_W-1:0] press_count
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] DCNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] DCNT_ONE  = CW'(1);
  localparam logic [CW-1:0] DCNT_LAST = CW'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic ONE_SHOT = (DEBOUNCE_CYCLES == 32'sd1);

  logic             key_sync_s;
  logic             pressed_s;
  logic             accept_s;
  logic [CW-1:0]    dcnt_inc_s;

  press_state_e     state_d, state_q;
  logic [CW-1:0]    dcnt_d, dcnt_q;
  logic             press_d, press_q;
  logic             held_d, held_q;
  logic [CNT_W-1:0] count_d, count_q;

  sync2 #(
    .RST_VAL (1'b1)
  ) u_sync (
    .clk     (clk),
    .rst_n   (reset),
    .async_i (key_n),
    .sync_o  (key_sync_s)
  );

  assign pressed_s  = ~key_sync_s;
  assign dcnt_inc_s = dcnt_q + DCNT_ONE;

  // debounce FSM: a level is accepted only after DEBOUNCE_CYCLES identical samples
  always_comb begin
    state_d  = state_q;
    dcnt_d   = dcnt_q;
    accept_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (pressed_s) begin
          if (ONE_SHOT) begin
            state_d  = PRESSED;
            dcnt_d   = DCNT_ZERO;
            accept_s = 1'b1;
          end else begin
            state_d = ARM;
            dcnt_d  = DCNT_ONE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ARM: begin
        if (pressed_s) begin
          if (dcnt_inc_s == DCNT_LAST) begin
            state_d  = PRESSED;
            dcnt_d   = DCNT_ZERO;
            accept_s = 1'b1;
          end else begin
            dcnt_d = dcnt_inc_s;
          end
        end else begin
          state_d = IDLE;
          dcnt_d  = DCNT_ZERO;
        end
      end
      PRESSED: begin
        if (!pressed_s) begin
          if (ONE_SHOT) begin
            state_d = IDLE;
            dcnt_d  = DCNT_ZERO;
          end else begin
            state_d = DROP;
            dcnt_d  = DCNT_ONE;
          end
        end else begin
          state_d = PRESSED;
        end
      end
      DROP: begin
        if (!pressed_s) begin
          if (dcnt_inc_s == DCNT_LAST) begin
            state_d = IDLE;
            dcnt_d  = DCNT_ZERO;
          end else begin
            dcnt_d = dcnt_inc_s;
          end
        end else begin
          // release bounce: back to held without a new pulse
          state_d = PRESSED;
          dcnt_d  = DCNT_ZERO;
        end
      end
      default: begin
        state_d = IDLE;
        dcnt_d  = DCNT_ZERO;
      end
    endcase
  end

  // output stage: lose masks the pulse and counter but not the debounced level
  always_comb begin
    press_d = accept_s & ~lose;
    held_d  = (state_d == PRESSED) || (state_d == DROP);
    if (press_d) begin
      count_d = count_q + CNT_ONE;
    end else begin
      count_d = count_q;
    end
  end

  // state, debounce counter and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      dcnt_q  <= DCNT_ZERO;
      press_q <= 1'b0;
      held_q  <= 1'b0;
      count_q <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
      press_q <= press_d;
      held_q  <= held_d;
      count_q <= count_d;
    end
  end

  assign press       = press_q;
  assign held        = held_q;
  assign press_count = count_q;

endmodule
